// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_engine
// Purpose  : Per-frame ball motion stage feeding the VGA ball renderer. Holds
//            position, velocity and radius, steps once per FRAME_DIV vertical
//            sync falling edges, reflects off screen edges and commits the new
//            centre atomically late in vertical blank.
// Ports    : clk, reset        - system clock, synchronous active-high reset
//            writedata/write/read/chipselect/address/readdata
//                              - 8-bit Avalon-MM slave, 8 registers
//            VGA_VS            - active-low vertical sync from the counters
//            ball_col/ball_row - committed centre (hcount[10:1] / vcount)
//            radius            - radius passed straight to the renderer
//            irq               - frame-step interrupt, level, active-high
// Config   : BALL_MOTION_IRQ_EN - when defined, enables the irq flag/output;
//            otherwise irq is tied low and status bit3 reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module ball_motion_engine #(
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] writedata,
  input  logic       write,
  input  logic       read,
  input  logic       chipselect,
  input  logic [2:0] address,
  output logic [7:0] readdata,
  input  logic       VGA_VS,
  output logic [9:0] ball_col,
  output logic [9:0] ball_row,
  output logic [7:0] radius,
  output logic       irq
);

  localparam logic signed [11:0] c_h_last = 12'(H_MAX - 1);
  localparam logic signed [11:0] c_v_last = 12'(V_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP_X = 2'd1,
    S_STEP_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_vs_d, r_tick;
  logic [7:0]        r_div;
  logic              r_run, r_irq_en;
  logic signed [7:0] r_vx, r_vy;
  logic [9:0]        r_ld_col, r_ld_row;
  logic              r_ld_pend;
  logic [7:0]        r_radius, r_rad_s;
  logic [9:0]        r_nx, r_ny, r_col, r_row;
  logic [2:0]        r_frame_cnt;
  logic              r_bounce_x, r_bounce_y, r_range_err;
  logic [7:0]        r_readdata;
  logic              w_irq_flag;

  logic w_wr, w_rd, w_idle, w_div_last, w_step, w_range_bad;
  logic signed [11:0] w_x_sum, w_x_lo, w_x_hi, w_y_sum, w_y_lo, w_y_hi;
  logic w_x_lo_hit, w_x_hi_hit, w_y_lo_hit, w_y_hi_hit;
  logic [9:0] w_x_new, w_y_new;

  // -128 has no positive counterpart in 8 bits; clamp to +127.
  function automatic logic signed [7:0] sat_neg(input logic signed [7:0] v);
    return (v == $signed(8'h80)) ? 8'sd127 : -v;
  endfunction

  assign w_wr       = chipselect & write;
  assign w_rd       = chipselect & read;
  assign w_idle     = (r_state == S_IDLE);
  assign w_div_last = (r_div == 8'(FRAME_DIV - 1));
  // Ticks arriving while a step is in flight are dropped entirely.
  assign w_step     = r_tick & w_idle & w_div_last;
  assign w_range_bad = ({3'b000, r_radius, 1'b0} >= 12'(V_MAX));

  // Horizontal: radius taken live in STEP_X, snapshot kept for STEP_Y.
  assign w_x_sum    = $signed({2'b00, r_col}) + $signed({{4{r_vx[7]}}, r_vx});
  assign w_x_lo     = $signed({4'b0000, r_radius});
  assign w_x_hi     = c_h_last - w_x_lo;
  assign w_x_lo_hit = (w_x_sum < w_x_lo);
  assign w_x_hi_hit = (w_x_sum > w_x_hi);
  assign w_x_new    = w_x_lo_hit ? {2'b00, r_radius} :
                      w_x_hi_hit ? w_x_hi[9:0] : w_x_sum[9:0];

  assign w_y_sum    = $signed({2'b00, r_row}) + $signed({{4{r_vy[7]}}, r_vy});
  assign w_y_lo     = $signed({4'b0000, r_rad_s});
  assign w_y_hi     = c_v_last - w_y_lo;
  assign w_y_lo_hit = (w_y_sum < w_y_lo);
  assign w_y_hi_hit = (w_y_sum > w_y_hi);
  assign w_y_new    = w_y_lo_hit ? {2'b00, r_rad_s} :
                      w_y_hi_hit ? w_y_hi[9:0] : w_y_sum[9:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_step && (r_run || r_ld_pend)) w_state_nxt = S_STEP_X;
      S_STEP_X: w_state_nxt = w_range_bad ? S_IDLE : S_STEP_Y;
      S_STEP_Y: w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

`ifdef BALL_MOTION_IRQ_EN
  logic r_irq_flag;
  assign w_irq_flag = r_irq_flag;
  assign irq        = r_irq_flag & r_irq_en;
`else
  assign w_irq_flag = 1'b0;
  assign irq        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_d      <= 1'b1;
      r_tick      <= 1'b0;
      r_div       <= 8'd0;
      r_run       <= 1'b0;
      r_irq_en    <= 1'b0;
      r_vx        <= 8'sd0;
      r_vy        <= 8'sd0;
      r_ld_col    <= 10'd0;
      r_ld_row    <= 10'd0;
      r_ld_pend   <= 1'b0;
      r_radius    <= 8'd16;
      r_rad_s     <= 8'd16;
      r_nx        <= 10'd320;
      r_ny        <= 10'd240;
      r_col       <= 10'd320;
      r_row       <= 10'd240;
      r_frame_cnt <= 3'd0;
      r_bounce_x  <= 1'b0;
      r_bounce_y  <= 1'b0;
      r_range_err <= 1'b0;
      r_readdata  <= 8'd0;
`ifdef BALL_MOTION_IRQ_EN
      r_irq_flag  <= 1'b0;
`endif
    end else begin
      r_vs_d <= VGA_VS;
      r_tick <= r_vs_d & ~VGA_VS;
      if (r_tick && w_idle) r_div <= w_div_last ? 8'd0 : r_div + 8'd1;

      // Flag clear goes first so a same-cycle set from the FSM wins.
      if (w_wr && address == 3'd7) begin
        r_bounce_x <= 1'b0;
        r_bounce_y <= 1'b0;
`ifdef BALL_MOTION_IRQ_EN
        r_irq_flag <= 1'b0;
`endif
      end

      case (r_state)
        S_STEP_X: begin
          if (w_range_bad) begin
            r_range_err <= 1'b1;
          end else begin
            r_rad_s <= r_radius;
            r_nx    <= w_x_new;
            if (w_x_lo_hit || w_x_hi_hit) begin
              r_vx       <= sat_neg(r_vx);
              r_bounce_x <= 1'b1;
            end
          end
        end
        S_STEP_Y: begin
          r_ny <= w_y_new;
          if (w_y_lo_hit || w_y_hi_hit) begin
            r_vy       <= sat_neg(r_vy);
            r_bounce_y <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_col       <= r_ld_pend ? r_ld_col : r_nx;
          r_row       <= r_ld_pend ? r_ld_row : r_ny;
          r_ld_pend   <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 3'd1;
`ifdef BALL_MOTION_IRQ_EN
          r_irq_flag  <= 1'b1;
`endif
        end
        default: ;
      endcase

      // Software writes come last so they override a same-cycle bounce.
      if (w_wr) begin
        case (address)
          3'd0: begin
            r_run    <= writedata[0];
            r_irq_en <= writedata[1];
          end
          3'd1: r_vx <= $signed(writedata);
          3'd2: r_vy <= $signed(writedata);
          3'd3: r_ld_col[9:2] <= writedata;
          3'd4: r_ld_row[9:2] <= writedata;
          3'd5: begin
            r_ld_row[1:0] <= writedata[3:2];
            r_ld_col[1:0] <= writedata[1:0];
            r_ld_pend     <= 1'b1;
          end
          3'd6: r_radius <= writedata;
          default: ;
        endcase
      end

      if (w_rd) begin
        case (address)
          3'd0:    r_readdata <= {6'd0, r_irq_en, r_run};
          3'd7:    r_readdata <= {r_range_err, r_bounce_y, r_bounce_x, ~w_idle,
                                  w_irq_flag, r_frame_cnt};
          default: r_readdata <= 8'd0;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign ball_col = r_col;
  assign ball_row = r_row;
  assign radius   = r_radius;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion_engine
// Purpose  : Directed self-checking bench for ball_motion_engine (default
//            parameters). Expected irq/status bit3 follow BALL_MOTION_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

`ifdef BALL_MOTION_IRQ_EN
  localparam bit c_irq = 1'b1;
`else
  localparam bit c_irq = 1'b0;
`endif
  localparam logic [7:0] c_ib = c_irq ? 8'h08 : 8'h00;

  logic       clk = 1'b0;
  logic       reset, wr, rd, cs, vga_vs;
  logic [7:0] wdata;
  logic [2:0] addr;
  logic [7:0] rdata;
  logic [9:0] col, row;
  logic [7:0] rad;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ball_motion_engine dut (
    .clk(clk), .reset(reset), .writedata(wdata), .write(wr), .read(rd),
    .chipselect(cs), .address(addr), .readdata(rdata), .VGA_VS(vga_vs),
    .ball_col(col), .ball_row(row), .radius(rad), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    check(tag, {24'd0, rdata}, {24'd0, exp});
  endtask

  task automatic check_pos(input string tag, input int c, input int r);
    check({tag, "_col"}, {22'd0, col}, c);
    check({tag, "_row"}, {22'd0, row}, r);
  endtask

  // One VS falling edge; optionally clears irq exactly in the COMMIT cycle.
  task automatic frame(input bit clr);
    @(posedge clk); #1; vga_vs = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    if (clr) begin cs = 1'b1; wr = 1'b1; addr = 3'd7; wdata = 8'h00; end
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1; vga_vs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ec[6] = '{475, 347, 219, 91, 16, 143};
    int er[6] = '{340, 440, 463, 363, 263, 163};
    reset = 1'b1; vga_vs = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = 3'd0; wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;

    // Reset state
    check_pos("rst", 320, 240);
    check("rst_radius", {24'd0, rad}, 16);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_readdata", {24'd0, rdata}, 0);
    check_read("rst_status", 3'd7, 8'h00);
    check_read("rst_ctrl", 3'd0, 8'h00);

    // run=0, no load: frame is ignored
    frame(1'b0);
    check_pos("idle_frame", 320, 240);
    check_read("idle_status", 3'd7, 8'h00);

    // vx=+5, vy=-3, exact commit timing
    bus_write(3'd1, 8'd5);
    bus_write(3'd2, 8'hFD);
    bus_write(3'd0, 8'h01);
    @(posedge clk); #1; vga_vs = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; cs = 1'b1; rd = 1'b1; addr = 3'd7;
    @(posedge clk); #1; cs = 1'b0; rd = 1'b0;
    check("busy_status", {24'd0, rdata}, 32'h10);
    @(posedge clk); #1;
    check_pos("pre_commit", 320, 240);
    @(posedge clk); #1;
    check_pos("commit", 325, 237);
    repeat (3) @(posedge clk);
    #1; vga_vs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_read("step_status", 3'd7, 8'h01 | c_ib);
    repeat (3) @(posedge clk);
    #1;
    check("rd_hold", {24'd0, rdata}, {24'd0, 8'h01 | c_ib});
    check_read("ctrl_rb", 3'd0, 8'h01);
    check("irq_masked", {31'd0, irq}, 0);

    // irq enable and clear
    bus_write(3'd0, 8'h03);
    check("irq_en", {31'd0, irq}, {31'd0, c_irq});
    bus_write(3'd7, 8'h00);
    check("irq_clr", {31'd0, irq}, 0);
    check_read("clr_status", 3'd7, 8'h01);

    // Position load then right-wall bounce
    bus_write(3'd3, 8'h9D);
    bus_write(3'd4, 8'h3C);
    bus_write(3'd5, 8'h02);
    bus_write(3'd1, 8'd20);
    bus_write(3'd2, 8'd0);
    check_read("addr3_rd", 3'd3, 8'h00);
    frame(1'b0);
    check_pos("load", 630, 240);
    frame(1'b0);
    check_pos("bounce_r", 623, 240);
    check_read("bounce_r_status", 3'd7, 8'h23 | c_ib);
    check("irq_set", {31'd0, irq}, {31'd0, c_irq});
    frame(1'b1);
    check_pos("after_bounce", 603, 240);
    check("irq_set_wins", {31'd0, irq}, {31'd0, c_irq});
    check_read("set_wins_status", 3'd7, 8'h04 | c_ib);

    // vx=-128 (saturating negation at left wall), vy=+100 (bottom wall)
    bus_write(3'd1, 8'h80);
    bus_write(3'd2, 8'h64);
    for (int i = 0; i < 6; i++) begin
      frame(1'b0);
      check_pos($sformatf("walk%0d", i), ec[i], er[i]);
    end
    check_read("walk_status", 3'd7, 8'h62 | c_ib);

    // Radius too large: step aborts, outputs hold
    bus_write(3'd7, 8'h00);
    bus_write(3'd6, 8'd240);
    check("radius_imm", {24'd0, rad}, 240);
    frame(1'b0);
    check_pos("range_hold", 143, 163);
    check_read("range_status", 3'd7, 8'h82);
    check("range_irq", {31'd0, irq}, 0);

    // Pending load with run=0 applies once, then idle
    bus_write(3'd6, 8'd16);
    bus_write(3'd0, 8'h00);
    bus_write(3'd3, 8'd25);
    bus_write(3'd4, 8'd12);
    bus_write(3'd5, 8'h08);
    frame(1'b0);
    check_pos("load_norun", 100, 50);
    frame(1'b0);
    check_pos("norun_hold", 100, 50);
    check_read("norun_status", 3'd7, 8'h83 | c_ib);

    // Reset in the middle of a step
    bus_write(3'd0, 8'h01);
    @(posedge clk); #1; vga_vs = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check_pos("mid_rst", 320, 240);
    check("mid_rst_radius", {24'd0, rad}, 16);
    check("mid_rst_irq", {31'd0, irq}, 0);
    repeat (3) @(posedge clk);
    #1; vga_vs = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_pos("post_rst", 320, 240);
    check_read("post_rst_status", 3'd7, 8'h00);
    check_read("post_rst_ctrl", 3'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
